vending_controller_gen: RTL

Parametrised next-generation vending controller. It accepts a tray/product selection, checks it against a per-slot stock table and a computed price, and drives a UPI payment handshake. On successful payment it runs the spring motor for a fixed time, decrements stock and pulses dispense. Unlike the single-shot controller, it adds configurable tray/product counts, stock tracking with restock, a payment timeout and explicit error codes. It sits between the front-panel selection logic and the upi_payment model/spring motor driver.

---
 rtl/vending_controller_gen.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/vending_controller_gen.sv
// Vending controller: validates a tray/product selection against a per-slot stock table,
// runs the UPI payment handshake, times the spring motor, then dispenses and decrements stock.
module vending_controller_gen #(
    parameter int NUM_TRAYS         = 6,
    parameter int PRODUCTS_PER_TRAY = 5,
    parameter int STOCK_W           = 4,
    parameter int INIT_STOCK        = 2,
    parameter int PRICE_W           = 8,
    parameter int PRICE_BASE        = 10,
    parameter int PRICE_TRAY_STEP   = 10,
    parameter int PRICE_PROD_STEP   = 5,
    parameter int PAY_TIMEOUT       = 64,
    parameter int MOTOR_CYCLES      = 16,
    localparam int TRAY_W = (NUM_TRAYS > 1) ? $clog2(NUM_TRAYS) : 1,
    localparam int PROD_W = (PRODUCTS_PER_TRAY > 1) ? $clog2(PRODUCTS_PER_TRAY) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel_valid,
    input  logic [TRAY_W-1:0]  tray_sel,
    input  logic [PROD_W-1:0]  product_sel,
    output logic               upi_pay_req,
    input  logic               upi_pay_done,
    input  logic               upi_pay_fail,
    input  logic               restock_en,
    input  logic [TRAY_W-1:0]  restock_tray,
    input  logic [PROD_W-1:0]  restock_product,
    input  logic [STOCK_W-1:0] restock_count,
    output logic               busy,
    output logic               spring_motor_en,
    output logic               dispense,
    output logic [PRICE_W-1:0] amount,
    output logic               error,
    output logic [2:0]         err_code
);

    localparam int TMR_W = (PAY_TIMEOUT > 1) ? $clog2(PAY_TIMEOUT) : 1;
    localparam int MOT_W = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;
    localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
    localparam logic [STOCK_W:0]   SUM_ONE   = 1;

    typedef enum logic [2:0] {
        IDLE, CHECK, PAY_REQ, PAY_WAIT, MOTOR, DONE, ERR
    } state_t;

    state_t             state_q, state_d;
    logic [TRAY_W-1:0]  tray_q, tray_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [MOT_W-1:0]   mcnt_q, mcnt_d;
    logic               pay_req_q, pay_req_d;
    logic               motor_q, motor_d;
    logic               dispense_q, dispense_d;
    logic [PRICE_W-1:0] amount_q, amount_d;
    logic               error_q, error_d;
    logic [2:0]         err_code_q, err_code_d;
    logic [2:0]         pend_q, pend_d;
    logic [STOCK_W-1:0] stock_q [NUM_TRAYS][PRODUCTS_PER_TRAY];
    logic [STOCK_W-1:0] stock_d [NUM_TRAYS][PRODUCTS_PER_TRAY];

    logic               sel_ok;
    logic               dec_stock;
    logic [STOCK_W-1:0] stock_cur;
    logic [STOCK_W:0]   ssum;

    always_comb begin
        sel_ok    = (int'(tray_q) < NUM_TRAYS) && (int'(prod_q) < PRODUCTS_PER_TRAY);
        stock_cur = '0;
        for (int t = 0; t < NUM_TRAYS; t++) begin
            for (int p = 0; p < PRODUCTS_PER_TRAY; p++) begin
                if (tray_q == TRAY_W'(t) && prod_q == PROD_W'(p)) stock_cur = stock_q[t][p];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tray_d     = tray_q;
        prod_d     = prod_q;
        timer_d    = timer_q;
        mcnt_d     = mcnt_q;
        amount_d   = amount_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        pend_d     = pend_q;
        pay_req_d  = 1'b0;
        motor_d    = 1'b0;
        dispense_d = 1'b0;
        dec_stock  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    tray_d     = tray_sel;
                    prod_d     = product_sel;
                    error_d    = 1'b0;
                    err_code_d = 3'd0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (!sel_ok) begin
                    pend_d   = 3'd1;
                    amount_d = '0;
                    state_d  = ERR;
                end else if (stock_cur == '0) begin
                    pend_d   = 3'd2;
                    amount_d = '0;
                    state_d  = ERR;
                end else begin
                    amount_d = PRICE_W'(PRICE_BASE + int'(tray_q) * PRICE_TRAY_STEP
                                                   + int'(prod_q) * PRICE_PROD_STEP);
                    state_d  = PAY_REQ;
                end
            end
            PAY_REQ: begin
                pay_req_d = 1'b1;
                timer_d   = '0;
                state_d   = PAY_WAIT;
            end
            PAY_WAIT: begin
                // A payment answer always beats the timeout; fail beats done.
                if (upi_pay_fail) begin
                    pend_d  = 3'd3;
                    state_d = ERR;
                end else if (upi_pay_done) begin
                    mcnt_d  = '0;
                    state_d = MOTOR;
                end else if (timer_q == TMR_W'(PAY_TIMEOUT - 1)) begin
                    pend_d  = 3'd4;
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            MOTOR: begin
                motor_d = 1'b1;
                if (mcnt_q == MOT_W'(MOTOR_CYCLES - 1)) begin
                    dec_stock = 1'b1;
                    state_d   = DONE;
                end else begin
                    mcnt_d = mcnt_q + 1'b1;
                end
            end
            DONE: begin
                dispense_d = 1'b1;
                state_d    = IDLE;
            end
            ERR: begin
                error_d    = 1'b1;
                err_code_d = pend_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Restock and the dispense decrement may hit one slot together: sat(stock - 1 + count).
    always_comb begin
        stock_d = stock_q;
        ssum    = '0;
        for (int t = 0; t < NUM_TRAYS; t++) begin
            for (int p = 0; p < PRODUCTS_PER_TRAY; p++) begin
                ssum = {1'b0, stock_q[t][p]};
                if (restock_en && restock_tray == TRAY_W'(t) && restock_product == PROD_W'(p))
                    ssum = ssum + {1'b0, restock_count};
                if (dec_stock && tray_q == TRAY_W'(t) && prod_q == PROD_W'(p) && ssum != '0)
                    ssum = ssum - SUM_ONE;
                stock_d[t][p] = ssum[STOCK_W] ? STOCK_MAX : ssum[STOCK_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tray_q     <= '0;
            prod_q     <= '0;
            timer_q    <= '0;
            mcnt_q     <= '0;
            pay_req_q  <= 1'b0;
            motor_q    <= 1'b0;
            dispense_q <= 1'b0;
            amount_q   <= '0;
            error_q    <= 1'b0;
            err_code_q <= 3'd0;
            pend_q     <= 3'd0;
            for (int t = 0; t < NUM_TRAYS; t++) begin
                for (int p = 0; p < PRODUCTS_PER_TRAY; p++) begin
                    stock_q[t][p] <= STOCK_W'(INIT_STOCK);
                end
            end
        end else begin
            state_q    <= state_d;
            tray_q     <= tray_d;
            prod_q     <= prod_d;
            timer_q    <= timer_d;
            mcnt_q     <= mcnt_d;
            pay_req_q  <= pay_req_d;
            motor_q    <= motor_d;
            dispense_q <= dispense_d;
            amount_q   <= amount_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            pend_q     <= pend_d;
            stock_q    <= stock_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign upi_pay_req     = pay_req_q;
    assign spring_motor_en = motor_q;
    assign dispense        = dispense_q;
    assign amount          = amount_q;
    assign error           = error_q;
    assign err_code        = err_code_q;

endmodule
